// File: rtl/stage_id_pipe.sv
// Instruction-decode pipeline stage: decodes one RV32I(+M) instruction, reads the register file
// combinationally and registers operands/control for EX, with load-use bubbles and EX flush.
module stage_id_pipe #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 6,
    parameter int ENABLE_M = 0,
    parameter int CNT_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [31:0]       i_inst,
    input  logic [XLEN-1:0]   i_inst_addr,
    input  logic [XLEN-1:0]   i_reg1_data,
    input  logic [XLEN-1:0]   i_reg2_data,
    output logic [REG_AW-1:0] o_reg1_rd_addr,
    output logic [REG_AW-1:0] o_reg2_rd_addr,
    input  logic              i_ex_jump_flag,
    input  logic              i_ex_ready,
    output logic              o_valid,
    output logic [XLEN-1:0]   o_op1,
    output logic [XLEN-1:0]   o_op2,
    output logic [XLEN-1:0]   o_op1_jump,
    output logic [XLEN-1:0]   o_op2_jump,
    output logic [31:0]       o_inst,
    output logic [XLEN-1:0]   o_inst_addr,
    output logic [XLEN-1:0]   o_reg1_data,
    output logic [XLEN-1:0]   o_reg2_data,
    output logic              o_reg_we,
    output logic [REG_AW-1:0] o_reg_wr_addr,
    output logic              o_mem_enable,
    output logic              o_is_load,
    output logic              o_is_muldiv,
    output logic              o_illegal,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [XLEN-1:0]   imm_i;
    logic [XLEN-1:0]   imm_s;
    logic [XLEN-1:0]   imm_b;
    logic [XLEN-1:0]   imm_j;
    logic [XLEN-1:0]   imm_u;

    assign opcode = i_inst[6:0];
    assign funct3 = i_inst[14:12];
    assign funct7 = i_inst[31:25];
    assign rd     = REG_AW'(i_inst[11:7]);
    assign rs1    = REG_AW'(i_inst[19:15]);
    assign rs2    = REG_AW'(i_inst[24:20]);
    assign imm_i  = XLEN'($signed(i_inst[31:20]));
    assign imm_s  = XLEN'($signed({i_inst[31:25], i_inst[11:7]}));
    assign imm_b  = XLEN'($signed({i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0}));
    assign imm_j  = XLEN'($signed({i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0}));
    assign imm_u  = XLEN'($signed({i_inst[31:12], 12'b0}));

    logic [XLEN-1:0]   d_op1;
    logic [XLEN-1:0]   d_op2;
    logic [XLEN-1:0]   d_op1_jump;
    logic [XLEN-1:0]   d_op2_jump;
    logic              d_reg_we;
    logic [REG_AW-1:0] d_wr_addr;
    logic              d_mem;
    logic              d_load;
    logic              d_muldiv;
    logic              d_illegal;
    logic              uses_rs1;
    logic              uses_rs2;

    always_comb begin
        d_op1      = '0;
        d_op2      = '0;
        d_op1_jump = '0;
        d_op2_jump = '0;
        d_reg_we   = 1'b0;
        d_wr_addr  = '0;
        d_mem      = 1'b0;
        d_load     = 1'b0;
        d_muldiv   = 1'b0;
        d_illegal  = 1'b0;
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        case (opcode)
            OPC_IMM: begin
                // Shift-immediates carry funct7 in imm[11:5]; only SRAI may use the alternate encoding.
                if ((funct3 == 3'b001 && funct7 != F7_ZERO) ||
                    (funct3 == 3'b101 && funct7 != F7_ZERO && funct7 != F7_ALT)) begin
                    d_illegal = 1'b1;
                end else begin
                    d_reg_we  = 1'b1;
                    d_wr_addr = rd;
                    uses_rs1  = 1'b1;
                    d_op1     = i_reg1_data;
                    d_op2     = imm_i;
                end
            end
            OPC_OP: begin
                if (funct7 == F7_MULDIV) begin
                    if (ENABLE_M != 0) begin
                        d_muldiv  = 1'b1;
                        d_reg_we  = 1'b1;
                        d_wr_addr = rd;
                        uses_rs1  = 1'b1;
                        uses_rs2  = 1'b1;
                        d_op1     = i_reg1_data;
                        d_op2     = i_reg2_data;
                    end else begin
                        d_illegal = 1'b1;
                    end
                end else if (funct7 == F7_ZERO ||
                             (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    d_reg_we  = 1'b1;
                    d_wr_addr = rd;
                    uses_rs1  = 1'b1;
                    uses_rs2  = 1'b1;
                    d_op1     = i_reg1_data;
                    d_op2     = i_reg2_data;
                end else begin
                    d_illegal = 1'b1;
                end
            end
            OPC_LOAD: begin
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
                    d_illegal = 1'b1;
                end else begin
                    d_reg_we  = 1'b1;
                    d_wr_addr = rd;
                    d_mem     = 1'b1;
                    d_load    = 1'b1;
                    uses_rs1  = 1'b1;
                    d_op1     = i_reg1_data;
                    d_op2     = imm_i;
                end
            end
            OPC_STORE: begin
                if (funct3[2] || funct3 == 3'b011) begin
                    d_illegal = 1'b1;
                end else begin
                    d_mem    = 1'b1;
                    uses_rs1 = 1'b1;
                    uses_rs2 = 1'b1;
                    d_op1    = i_reg1_data;
                    d_op2    = imm_s;
                end
            end
            OPC_BRANCH: begin
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    d_illegal = 1'b1;
                end else begin
                    uses_rs1   = 1'b1;
                    uses_rs2   = 1'b1;
                    d_op1      = i_reg1_data;
                    d_op2      = i_reg2_data;
                    d_op1_jump = i_inst_addr;
                    d_op2_jump = imm_b;
                end
            end
            OPC_JAL: begin
                d_reg_we   = 1'b1;
                d_wr_addr  = rd;
                d_op1      = i_inst_addr;
                d_op2      = XLEN'(4);
                d_op1_jump = i_inst_addr;
                d_op2_jump = imm_j;
            end
            OPC_JALR: begin
                if (funct3 != 3'b000) begin
                    d_illegal = 1'b1;
                end else begin
                    d_reg_we   = 1'b1;
                    d_wr_addr  = rd;
                    uses_rs1   = 1'b1;
                    d_op1      = i_inst_addr;
                    d_op2      = XLEN'(4);
                    d_op1_jump = i_reg1_data;
                    d_op2_jump = imm_i;
                end
            end
            OPC_LUI: begin
                d_reg_we  = 1'b1;
                d_wr_addr = rd;
                d_op1     = imm_u;
            end
            OPC_AUIPC: begin
                d_reg_we  = 1'b1;
                d_wr_addr = rd;
                d_op1     = i_inst_addr;
                d_op2     = imm_u;
            end
            default: d_illegal = 1'b1;
        endcase
    end

    assign o_reg1_rd_addr = uses_rs1 ? rs1 : '0;
    assign o_reg2_rd_addr = uses_rs2 ? rs2 : '0;

    // Handshake: an input is consumed on a rising edge where i_valid & o_ready; o_valid holds a
    // live instruction that EX takes on an edge with i_ex_ready. A flush always consumes (and
    // drops) the input; a load-use hazard holds it back for exactly one bubble cycle.
    logic adv;
    logic hazard;

    assign adv    = i_ex_ready | ~o_valid;
    assign hazard = o_valid & o_is_load & (o_reg_wr_addr != '0) & i_valid &
                    ((uses_rs1 & (rs1 == o_reg_wr_addr)) | (uses_rs2 & (rs2 == o_reg_wr_addr)));
    assign o_ready = ~i_rst & (i_ex_jump_flag | (adv & ~hazard));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid       <= 1'b0;
            o_op1         <= '0;
            o_op2         <= '0;
            o_op1_jump    <= '0;
            o_op2_jump    <= '0;
            o_inst        <= '0;
            o_inst_addr   <= '0;
            o_reg1_data   <= '0;
            o_reg2_data   <= '0;
            o_reg_we      <= 1'b0;
            o_reg_wr_addr <= '0;
            o_mem_enable  <= 1'b0;
            o_is_load     <= 1'b0;
            o_is_muldiv   <= 1'b0;
            o_illegal     <= 1'b0;
            o_stall_cnt   <= '0;
        end else if (i_ex_jump_flag || (adv && hazard)) begin
            // Data fields are left as-is; only the control that could cause side effects is cleared.
            o_valid      <= 1'b0;
            o_reg_we     <= 1'b0;
            o_mem_enable <= 1'b0;
            o_is_load    <= 1'b0;
            o_is_muldiv  <= 1'b0;
            o_illegal    <= 1'b0;
            if (!i_ex_jump_flag && o_stall_cnt != '1) begin
                o_stall_cnt <= o_stall_cnt + CNT_W'(1);
            end
        end else if (adv) begin
            o_valid       <= i_valid;
            o_op1         <= d_op1;
            o_op2         <= d_op2;
            o_op1_jump    <= d_op1_jump;
            o_op2_jump    <= d_op2_jump;
            o_inst        <= i_inst;
            o_inst_addr   <= i_inst_addr;
            o_reg1_data   <= i_reg1_data;
            o_reg2_data   <= i_reg2_data;
            o_reg_wr_addr <= d_wr_addr;
            o_reg_we      <= i_valid & d_reg_we;
            o_mem_enable  <= i_valid & d_mem;
            o_is_load     <= i_valid & d_load;
            o_is_muldiv   <= i_valid & d_muldiv;
            o_illegal     <= i_valid & d_illegal;
        end
    end

endmodule
